// File: rtl/load_store_unit.sv
// load_store_unit
//
// Multi-cycle load/store stage that sits behind the ALU. The ALU result is
// the effective byte address and the second register operand is the store
// data. Each access runs one valid/ready transaction on the data-memory bus.
// A load result is size-extended and returned to writeback. The upstream
// pipeline is held with `stall` until the access finishes.
//
// Optional feature macro: LSU_MISALIGN_TRAP_EN
//   defined   : misaligned half/word accesses trap (FAULT state, misalign
//               pulse, no bus activity)
//   undefined : misaligned addresses are silently aligned and misalign is 0
//
// Ports
//   clk, rst_n        : clock, synchronous active-low reset
//   memReq            : current instruction is a load or store (held while stalled)
//   memWrite          : 1 = store, 0 = load
//   memSize           : 00 byte, 01 half, 10/11 word
//   memUnsigned       : zero-extend loads when 1, sign-extend when 0
//   ALUout            : effective byte address
//   regOp2            : store data (low bits used for byte/half)
//   stall             : freeze upstream pipeline
//   done              : one-cycle completion pulse
//   loadData          : extended load result, held between loads
//   misalign          : one-cycle fault pulse (trap build only)
//   busValid/busAddr/busWe/busWdata/busWstrb : request channel
//   busReady          : bus accepts the request
//   busRvalid/busRdata: read-data return channel

module load_store_unit #(
  parameter int DATAWIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 memReq,
  input  logic                 memWrite,
  input  logic [1:0]           memSize,
  input  logic                 memUnsigned,
  input  logic [DATAWIDTH-1:0] ALUout,
  input  logic [DATAWIDTH-1:0] regOp2,
  output logic                 stall,
  output logic                 done,
  output logic [DATAWIDTH-1:0] loadData,
  output logic                 misalign,
  output logic                 busValid,
  output logic [DATAWIDTH-1:0] busAddr,
  output logic                 busWe,
  output logic [DATAWIDTH-1:0] busWdata,
  output logic [3:0]           busWstrb,
  input  logic                 busReady,
  input  logic                 busRvalid,
  input  logic [DATAWIDTH-1:0] busRdata
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT_R,
    ST_DONE
`ifdef LSU_MISALIGN_TRAP_EN
    , ST_FAULT
`endif
  } state_t;

  state_t                 state_q, state_d;
  logic [DATAWIDTH-1:0]   addr_q, addr_d;
  logic [DATAWIDTH-1:0]   wdata_q, wdata_d;
  logic [3:0]             wstrb_q, wstrb_d;
  logic                   we_q, we_d;
  logic [1:0]             size_q, size_d;
  logic                   unsigned_q, unsigned_d;
  logic [DATAWIDTH-1:0]   load_q, load_d;

  logic [3:0]             req_strb;
  logic [DATAWIDTH-1:0]   req_wdata;
  logic [7:0]             lane_b;
  logic [15:0]            lane_h;
  logic [DATAWIDTH-1:0]   load_ext;
`ifdef LSU_MISALIGN_TRAP_EN
  logic                   req_misaligned;
`endif

  // Strobe and lane-replicated write data for the incoming request. These are
  // computed from the live inputs and captured when IDLE accepts the request,
  // so the bus sees stable values for the whole REQ phase. A half access only
  // looks at addr[1] and a word access ignores addr[1:0], which is what
  // aligns misaligned addresses in the non-trapping build.
  always_comb begin
    req_strb  = 4'b0000;
    req_wdata = regOp2;
    if (memWrite) begin
      case (memSize)
        2'b00: begin
          req_strb  = 4'b0001 << ALUout[1:0];
          req_wdata = {4{regOp2[7:0]}};
        end
        2'b01: begin
          req_strb  = 4'b0011 << {ALUout[1], 1'b0};
          req_wdata = {2{regOp2[15:0]}};
        end
        default: begin
          req_strb  = 4'b1111;
          req_wdata = regOp2;
        end
      endcase
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  // A half needs an even address, a word needs a 4-byte aligned address.
  always_comb begin
    req_misaligned = 1'b0;
    case (memSize)
      2'b00:   req_misaligned = 1'b0;
      2'b01:   req_misaligned = ALUout[0];
      default: req_misaligned = (ALUout[1:0] != 2'b00);
    endcase
  end
`endif

  // Lane selection and extension of the returned read word, using the
  // latched address and size of the access in flight.
  always_comb begin
    lane_b = busRdata[7:0];
    case (addr_q[1:0])
      2'b00: lane_b = busRdata[7:0];
      2'b01: lane_b = busRdata[15:8];
      2'b10: lane_b = busRdata[23:16];
      2'b11: lane_b = busRdata[31:24];
      default: lane_b = busRdata[7:0];
    endcase
    lane_h = addr_q[1] ? busRdata[31:16] : busRdata[15:0];
    case (size_q)
      2'b00:   load_ext = unsigned_q ? {24'b0, lane_b} : {{24{lane_b[7]}}, lane_b};
      2'b01:   load_ext = unsigned_q ? {16'b0, lane_h} : {{16{lane_h[15]}}, lane_h};
      default: load_ext = busRdata;
    endcase
  end

  // Next-state logic. Every register holds by default; IDLE captures the
  // request, REQ waits for the handshake, WAIT_R waits for read data and
  // updates the load result. DONE/FAULT last one cycle and ignore memReq,
  // which gives the one-cycle bubble between back-to-back accesses.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    we_d       = we_q;
    size_d     = size_q;
    unsigned_d = unsigned_q;
    load_d     = load_q;
    case (state_q)
      ST_IDLE: begin
        if (memReq) begin
          addr_d     = ALUout;
          wdata_d    = req_wdata;
          wstrb_d    = req_strb;
          we_d       = memWrite;
          size_d     = memSize;
          unsigned_d = memUnsigned;
`ifdef LSU_MISALIGN_TRAP_EN
          state_d    = req_misaligned ? ST_FAULT : ST_REQ;
`else
          state_d    = ST_REQ;
`endif
        end
      end
      ST_REQ: begin
        if (busReady) begin
          state_d = we_q ? ST_DONE : ST_WAIT_R;
        end
      end
      ST_WAIT_R: begin
        if (busRvalid) begin
          load_d  = load_ext;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
`ifdef LSU_MISALIGN_TRAP_EN
      ST_FAULT: state_d = ST_IDLE;
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers. Reset abandons any access in flight and
  // clears the latched request so all bus outputs read back as zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= 4'b0000;
      we_q       <= 1'b0;
      size_q     <= 2'b00;
      unsigned_q <= 1'b0;
      load_q     <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      we_q       <= we_d;
      size_q     <= size_d;
      unsigned_q <= unsigned_d;
      load_q     <= load_d;
    end
  end

  // Outputs. Bus fields are gated by REQ so they are zero whenever no request
  // is being presented. stall is combinational on memReq so the requesting
  // instruction is frozen in the very cycle it arrives.
  always_comb begin
    stall    = ((state_q == ST_IDLE) && memReq) ||
               (state_q == ST_REQ) || (state_q == ST_WAIT_R);
    busValid = (state_q == ST_REQ);
    busAddr  = busValid ? {addr_q[DATAWIDTH-1:2], 2'b00} : '0;
    busWe    = busValid && we_q;
    busWdata = busValid ? wdata_q : '0;
    busWstrb = busValid ? wstrb_q : 4'b0000;
    loadData = load_q;
`ifdef LSU_MISALIGN_TRAP_EN
    done     = (state_q == ST_DONE) || (state_q == ST_FAULT);
    misalign = (state_q == ST_FAULT);
`else
    done     = (state_q == ST_DONE);
    misalign = 1'b0;
`endif
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit
//
// Self-checking bench for load_store_unit. A transaction-level model works
// out, for each access, the cycle-by-cycle timeline (handshake cycle, read
// data cycle, completion cycle) and the expected bus fields and load result
// from byte arithmetic. One compare process checks the DUT against the
// expectations on every falling edge. Directed accesses additionally pin the
// model with hand-computed literal values.

module tb_load_store_unit;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        mem_req;
  logic        mem_write;
  logic [1:0]  mem_size;
  logic        mem_unsigned;
  logic [31:0] alu_out;
  logic [31:0] reg_op2;
  logic        stall;
  logic        done;
  logic [31:0] load_data;
  logic        misalign;
  logic        bus_valid;
  logic [31:0] bus_addr;
  logic        bus_we;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_ready;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  load_store_unit #(.DATAWIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .memReq     (mem_req),
    .memWrite   (mem_write),
    .memSize    (mem_size),
    .memUnsigned(mem_unsigned),
    .ALUout     (alu_out),
    .regOp2     (reg_op2),
    .stall      (stall),
    .done       (done),
    .loadData   (load_data),
    .misalign   (misalign),
    .busValid   (bus_valid),
    .busAddr    (bus_addr),
    .busWe      (bus_we),
    .busWdata   (bus_wdata),
    .busWstrb   (bus_wstrb),
    .busReady   (bus_ready),
    .busRvalid  (bus_rvalid),
    .busRdata   (bus_rdata)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expectations for the current cycle, written by the stimulus process.
  logic        chk_en = 1'b0;
  logic        exp_stall, exp_valid, exp_done, exp_mis, exp_we, exp_bus_zero;
  logic [31:0] exp_load, exp_addr, exp_wdata;
  logic [3:0]  exp_strb;
  int          cur_k;
  logic [31:0] model_load;

  // Literal check request handed to the compare process.
  logic        lit_on = 1'b0;
  string       lit_name;
  int          lit_sel;
  logic [31:0] lit_exp;
  int          lit_base;

  // Compare-process bookkeeping.
  int          errors = 0;
  int          checks = 0;
  int          done_total = 0;
  int          valid_total = 0;
  logic [31:0] seen_addr, seen_wdata;
  logic [3:0]  seen_wstrb;
  int          seen_done_k;

  // ---------------- behavioural model ----------------
  function automatic bit misaligned(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'b00) return 1'b0;
    if (sz == 2'b01) return a[0];
    return a[1:0] != 2'b00;
  endfunction

  function automatic logic [31:0] modelWdata(input logic [1:0] sz, input logic [31:0] d);
    if (sz == 2'b00) return 32'(d[7:0]) * 32'h0101_0101;
    if (sz == 2'b01) return 32'(d[15:0]) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [3:0] modelStrb(input logic wr, input logic [1:0] sz, input logic [31:0] a);
    if (!wr) return 4'h0;
    if (sz == 2'b00) return 4'(1 << a[1:0]);
    if (sz == 2'b01) return 4'(3 << (2 * a[1]));
    return 4'hF;
  endfunction

  function automatic logic [31:0] modelExtend(input logic [1:0] sz, input logic uns,
                                              input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] v;
    if (sz == 2'b00) begin
      v = (rd >> (8 * a[1:0])) & 32'hFF;
      if (!uns && v >= 32'd128) v = v + 32'hFFFF_FF00;
    end else if (sz == 2'b01) begin
      v = (rd >> (16 * a[1])) & 32'hFFFF;
      if (!uns && v >= 32'd32768) v = v + 32'hFFFF_0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  function automatic logic rb();
    return 1'($urandom & 1);
  endfunction

  // ---------------- compare process ----------------
  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at t=%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic checkOutput();
    checkVal("stall",    32'(stall),    32'(exp_stall));
    checkVal("busValid", 32'(bus_valid), 32'(exp_valid));
    checkVal("done",     32'(done),     32'(exp_done));
    checkVal("misalign", 32'(misalign), 32'(exp_mis));
    checkVal("loadData", load_data,     exp_load);
    if (exp_valid) begin
      checkVal("busAddr",  bus_addr,        exp_addr);
      checkVal("busWe",    32'(bus_we),     32'(exp_we));
      checkVal("busWstrb", 32'(bus_wstrb),  32'(exp_strb));
      if (exp_we) checkVal("busWdata", bus_wdata, exp_wdata);
    end
    if (exp_bus_zero) begin
      checkVal("rst_busAddr",  bus_addr,       32'h0);
      checkVal("rst_busWe",    32'(bus_we),    32'h0);
      checkVal("rst_busWdata", bus_wdata,      32'h0);
      checkVal("rst_busWstrb", 32'(bus_wstrb), 32'h0);
    end
    if (bus_valid === 1'b1) begin
      valid_total++;
      seen_addr  = bus_addr;
      seen_wdata = bus_wdata;
      seen_wstrb = bus_wstrb;
    end
    if (done === 1'b1) begin
      done_total++;
      seen_done_k = cur_k;
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) checkOutput();
    if (lit_on) begin
      case (lit_sel)
        0: checkVal(lit_name, seen_addr, lit_exp);
        1: checkVal(lit_name, 32'(seen_wstrb), lit_exp);
        2: checkVal(lit_name, seen_wdata, lit_exp);
        3: checkVal(lit_name, load_data, lit_exp);
        4: checkVal(lit_name, 32'(seen_done_k), lit_exp);
        5: checkVal(lit_name, 32'(done_total - lit_base), lit_exp);
        default: checkVal(lit_name, 32'(valid_total - lit_base), lit_exp);
      endcase
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic req, input logic wr, input logic [1:0] sz,
                               input logic uns, input logic [31:0] addr, input logic [31:0] data,
                               input logic rdy, input logic rv, input logic [31:0] rdata);
    mem_req      = req;
    mem_write    = wr;
    mem_size     = sz;
    mem_unsigned = uns;
    alu_out      = addr;
    reg_op2      = data;
    bus_ready    = rdy;
    bus_rvalid   = rv;
    bus_rdata    = rdata;
  endtask

  task automatic setIdleExp();
    exp_stall    = 1'b0;
    exp_valid    = 1'b0;
    exp_done     = 1'b0;
    exp_mis      = 1'b0;
    exp_load     = model_load;
    exp_bus_zero = 1'b0;
  endtask

  // Idle cycles with bus noise, which IDLE must ignore.
  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, rb(), 2'($urandom), rb(), $urandom, $urandom, rb(), rb(), $urandom);
      setIdleExp();
      step();
    end
  endtask

  task automatic litCheck(input string name, input int sel, input logic [31:0] exp, input int base);
    lit_name = name;
    lit_sel  = sel;
    lit_exp  = exp;
    lit_base = base;
    lit_on   = 1'b1;
    idleCycles(1);
    lit_on   = 1'b0;
  endtask

  // One access. Cycle 0 presents the request; the handshake happens in cycle
  // h after rdy_dly cycles of busReady low; read data arrives in cycle r after
  // rv_dly empty WAIT_R cycles; done is in cycle dc. Inputs that the DUT must
  // ignore in a given cycle are randomized.
  task automatic runTxn(input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] data,
                        input logic [31:0] rdata, input int rdy_dly, input int rv_dly);
    bit          fault;
    int          h, r, dc;
    logic [31:0] new_load;
    logic        rdy, rv;
    fault    = TRAP && misaligned(sz, addr);
    h        = 1 + rdy_dly;
    r        = h + 1 + rv_dly;
    dc       = fault ? 1 : (wr ? h + 1 : r + 1);
    new_load = (fault || wr) ? model_load : modelExtend(sz, uns, addr, rdata);
    exp_addr  = addr & ~32'h3;
    exp_we    = wr;
    exp_strb  = modelStrb(wr, sz, addr);
    exp_wdata = modelWdata(sz, data);
    exp_bus_zero = 1'b0;
    for (int k = 0; k <= dc; k++) begin
      cur_k = k;
      if (fault)                 rdy = rb();
      else if (k == h)           rdy = 1'b1;
      else if (k >= 1 && k < h)  rdy = 1'b0;
      else                       rdy = rb();
      if (fault || wr)           rv = rb();
      else if (k == r)           rv = 1'b1;
      else if (k > h && k < r)   rv = 1'b0;
      else                       rv = rb();
      if (k < dc)
        applyStimulus(1'b1, wr, sz, uns, addr, data, rdy, rv, (k == r) ? rdata : $urandom);
      else
        applyStimulus(rb(), rb(), 2'($urandom), rb(), $urandom, $urandom, rdy, rv, $urandom);
      exp_stall = (k < dc);
      exp_valid = !fault && k >= 1 && k <= h;
      exp_done  = (k == dc);
      exp_mis   = (k == dc) && fault;
      exp_load  = (k == dc) ? new_load : model_load;
      step();
    end
    model_load = new_load;
  endtask

  // Safety net: the stimulus is fully scheduled, so this only fires on a hang.
  initial begin
    #2_000_000;
    $display("[TB] FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  initial begin
    int base_d, base_v;
    model_load = 32'h0;
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    step();

    // Reset state; stall follows memReq even while reset is held.
    chk_en = 1'b1;
    setIdleExp();
    exp_bus_zero = 1'b1;
    applyStimulus(1'b1, 1'b1, 2'b10, 1'b0, 32'h104, 32'h5, 1'b1, 1'b1, 32'h0);
    exp_stall = 1'b1;
    step();
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    setIdleExp();
    exp_bus_zero = 1'b1;
    step();
    idleCycles(1);

    // Word store, no wait states.
    base_d = done_total;
    runTxn(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEAD_BEEF, 32'h0, 0, 0);
    litCheck("sw_addr", 0, 32'h100, 0);
    litCheck("sw_strb", 1, 32'hF, 0);
    litCheck("sw_wdata", 2, 32'hDEAD_BEEF, 0);
    litCheck("sw_done_cycle", 4, 32'd2, 0);
    litCheck("sw_one_done", 5, 32'd1, base_d);

    // Byte load, signed then unsigned.
    runTxn(1'b0, 2'b00, 1'b0, 32'h203, 32'h0, 32'h80FF_FFFF, 0, 0);
    litCheck("lb_signed", 3, 32'hFFFF_FF80, 0);
    litCheck("lb_done_cycle", 4, 32'd3, 0);
    runTxn(1'b0, 2'b00, 1'b1, 32'h203, 32'h0, 32'h80FF_FFFF, 0, 0);
    litCheck("lbu", 3, 32'h0000_0080, 0);

    // Half store to the upper half-word.
    runTxn(1'b1, 2'b01, 1'b0, 32'h102, 32'h1234_ABCD, 32'h0, 0, 0);
    litCheck("sh_strb", 1, 32'hC, 0);
    litCheck("sh_wdata", 2, 32'hABCD_ABCD, 0);

    // Slow bus: ready after 5 cycles, read data 3 cycles later.
    base_d = done_total;
    base_v = valid_total;
    runTxn(1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 32'hCAFE_F00D, 5, 3);
    litCheck("slow_one_done", 5, 32'd1, base_d);
    litCheck("slow_valid_cycles", 6, 32'd6, base_v);
    litCheck("slow_done_cycle", 4, 32'd11, 0);
    litCheck("slow_load", 3, 32'hCAFE_F00D, 0);

    // Misaligned word load.
    base_v = valid_total;
    runTxn(1'b0, 2'b10, 1'b0, 32'h102, 32'h0, 32'h1122_3344, 0, 0);
`ifdef LSU_MISALIGN_TRAP_EN
    litCheck("mis_done_cycle", 4, 32'd1, 0);
    litCheck("mis_no_bus", 6, 32'd0, base_v);
    litCheck("mis_load_held", 3, 32'hCAFE_F00D, 0);
`else
    litCheck("mis_aligned_addr", 0, 32'h100, 0);
    litCheck("mis_done_cycle", 4, 32'd3, 0);
    litCheck("mis_load", 3, 32'h1122_3344, 0);
`endif

    // Reset while waiting for read data, then a late busRvalid.
    base_d = done_total;
    exp_addr = 32'h300; exp_we = 1'b0; exp_strb = 4'h0; exp_wdata = 32'h0;
    applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 1'b0, 1'b0, 32'h0);
    setIdleExp(); exp_stall = 1'b1;
    step();
    applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 1'b1, 1'b0, 32'h0);
    setIdleExp(); exp_stall = 1'b1; exp_valid = 1'b1;
    step();
    applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 1'b0, 1'b0, 32'h0);
    rst_n = 1'b0;
    setIdleExp(); exp_stall = 1'b1;
    step();
    rst_n = 1'b1;
    model_load = 32'h0;
    applyStimulus(1'b0, 1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 1'b0, 1'b1, 32'h1234_5678);
    setIdleExp(); exp_bus_zero = 1'b1;
    step();
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 1'b0, 1'b1, 32'h1234_5678);
      setIdleExp();
      step();
    end
    litCheck("rst_no_done", 5, 32'd0, base_d);
    litCheck("rst_load_zero", 3, 32'h0, 0);

    // Randomized accesses with random wait states and gaps.
    for (int t = 0; t < 200; t++) begin
      logic [1:0]  sz;
      logic [31:0] addr;
      sz   = 2'($urandom);
      addr = $urandom;
      if (($urandom % 3) == 0) addr[1:0] = 2'b00;
      runTxn(rb(), sz, rb(), addr, $urandom, $urandom,
             int'($urandom % 4), int'($urandom % 4));
      idleCycles(int'($urandom % 3));
    end

    idleCycles(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
